// File: rtl/execute_alu.sv
// Integer ALU execution unit: evaluates OP / OP-IMM / LUI / AUIPC micro-ops, drives a
// same-cycle bypass bus and a one-cycle registered writeback.
module execute_alu #(
    parameter int WIDTH_BRM = 4,
    parameter int WIDTH_REG = 7
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [6:0]             i_uop,
    input  logic [9:0]             i_func,
    input  logic [WIDTH_REG-1:0]   i_addr,
    input  logic [31:0]            i_PC,
    input  logic [31:0]            i_op1,
    input  logic [31:0]            i_op2,
    input  logic [31:0]            i_imm,
    output logic                   o_valid,
    output logic [WIDTH_REG-1:0]   o_addr,
    output logic [31:0]            o_data,
    output logic [WIDTH_REG+32:0]  o_bypass
);

    // Valid-only interface: a micro-op is accepted on every rising edge where i_valid=1;
    // there is no ready/stall, and o_valid marks the writeback produced one cycle later.

    // Branch-mask width is carried for core-wide consistency only.
    localparam int unused_brm_width = WIDTH_BRM;

    localparam logic [6:0] UOP_OP    = 7'b0110011;
    localparam logic [6:0] UOP_OPIMM = 7'b0010011;
    localparam logic [6:0] UOP_LUI   = 7'b0110111;
    localparam logic [6:0] UOP_AUIPC = 7'b0010111;

    logic [2:0]  f3;
    logic        alt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        unused_func_bits;

    assign f3               = i_func[2:0];
    assign alt              = i_func[8];
    assign opa              = i_op1;
    assign opb              = (i_uop == UOP_OPIMM) ? i_imm : i_op2;
    assign shamt            = opb[4:0];
    assign unused_func_bits = ^{i_func[9], i_func[7:3]};

    always_comb begin
        result = 32'h0;
        case (i_uop)
            UOP_OP, UOP_OPIMM: begin
                case (f3)
                    3'b000: begin
                        // Immediate forms have no SUB; funct7 bit 5 is ignored there.
                        if (i_uop == UOP_OP && alt) result = opa - opb;
                        else                        result = opa + opb;
                    end
                    3'b001: result = opa << shamt;
                    3'b010: result = {31'h0, $signed(opa) < $signed(opb)};
                    3'b011: result = {31'h0, opa < opb};
                    3'b100: result = opa ^ opb;
                    3'b101: begin
                        if (alt) result = $signed(opa) >>> shamt;
                        else     result = opa >> shamt;
                    end
                    3'b110: result = opa | opb;
                    3'b111: result = opa & opb;
                    default: result = 32'h0;
                endcase
            end
            UOP_LUI:   result = i_imm;
            UOP_AUIPC: result = i_PC + i_imm;
            default:   result = 32'h0;
        endcase
    end

    assign o_bypass = {i_valid, i_addr, result};

    // Address and data follow the inputs even when i_valid=0; consumers qualify with o_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_data  <= 32'h0;
        end else begin
            o_valid <= i_valid;
            o_addr  <= i_addr;
            o_data  <= result;
        end
    end

endmodule

// File: tb/tb_execute_alu.sv
// Bench for execute_alu: directed micro-ops, an arithmetic reference model, and a
// writeback scoreboard fed one entry per driven cycle.
module tb_execute_alu;

    localparam int WR = 7;
    localparam int BW = 1 + WR + 32;
    localparam logic [6:0] U_OP    = 7'b0110011;
    localparam logic [6:0] U_IMM   = 7'b0010011;
    localparam logic [6:0] U_LUI   = 7'b0110111;
    localparam logic [6:0] U_AUIPC = 7'b0010111;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic [6:0]    uop;
    logic [9:0]    func;
    logic [WR-1:0] addr;
    logic [31:0]   pc, op1, op2, imm;
    logic          o_valid;
    logic [WR-1:0] o_addr;
    logic [31:0]   o_data;
    logic [BW-1:0] bypass;

    logic [BW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    execute_alu #(.WIDTH_BRM(4), .WIDTH_REG(WR)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_uop    (uop),
        .i_func   (func),
        .i_addr   (addr),
        .i_PC     (pc),
        .i_op1    (op1),
        .i_op2    (op2),
        .i_imm    (imm),
        .o_valid  (o_valid),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .o_bypass (bypass)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        valid = 1'b0; uop = '0; func = '0; addr = '0;
        pc = '0; op1 = '0; op2 = '0; imm = '0;
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain wide-integer arithmetic, wrapped to 32 bits at the end.
    function automatic logic [31:0] model(input logic [6:0] u, input logic [9:0] fn,
                                          input logic [31:0] p, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] im);
        longint a, b, sa, sb, pw, q, r;
        logic [31:0] b32;
        int sh;
        b32 = (u == U_IMM) ? im : y;
        a   = longint'({32'h0, x});
        b   = longint'({32'h0, b32});
        sa  = longint'($signed(x));
        sb  = longint'($signed(b32));
        sh  = int'(b32 % 32);
        pw  = 64'sd1 << sh;
        r   = 0;
        if (u == U_OP || u == U_IMM) begin
            case (fn[2:0])
                3'd0: r = (u == U_OP && fn[8]) ? (a - b + 64'sd4294967296) : (a + b);
                3'd1: r = a * pw;
                3'd2: r = (sa < sb) ? 1 : 0;
                3'd3: r = (a < b) ? 1 : 0;
                3'd4: r = longint'({32'h0, x ^ b32});
                3'd5: begin
                    if (fn[8]) begin
                        q = sa / pw;
                        if (sa < 0 && (sa % pw) != 0) q = q - 1;
                        r = q;
                    end else begin
                        r = a / pw;
                    end
                end
                3'd6: r = longint'({32'h0, x | b32});
                default: r = longint'({32'h0, x & b32});
            endcase
        end else if (u == U_LUI) begin
            r = longint'({32'h0, im});
        end else if (u == U_AUIPC) begin
            r = longint'({32'h0, p}) + longint'({32'h0, im});
        end
        return r[31:0];
    endfunction

    // Driver: applies one micro-op per cycle, checks the bypass bus, queues the writeback.
    task automatic drive(input string name, input logic v, input logic [6:0] u,
                         input logic [9:0] fn, input logic [WR-1:0] ad, input logic [31:0] p,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] im,
                         input logic has_lit, input logic [31:0] lit);
        logic [31:0] m;
        @(negedge clk);
        valid = v; uop = u; func = fn; addr = ad; pc = p; op1 = x; op2 = y; imm = im;
        m = model(u, fn, p, x, y, im);
        if (has_lit) check({name, " model"}, BW'(m), BW'(lit));
        #1;
        check({name, " bypass"}, bypass, {v, ad, m});
        exp_q.push_back({v, ad, m});
    endtask

    // Scoreboard: one writeback entry per rising edge outside reset.
    initial begin
        logic [BW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("writeback", {o_valid, o_addr, o_data}, e);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {o_valid, o_addr, o_data}, '0);
        #2 rst_n = 1'b1;

        drive("add",    1, U_OP,    10'h000, 7'd2, 32'd0, 32'd2, 32'd3, 32'd0, 1, 32'd5);
        drive("lui",    1, U_LUI,   10'h000, 7'd2, 32'd0, 32'd2, 32'd3, 32'd1, 1, 32'd1);
        drive("auipc",  1, U_AUIPC, 10'h000, 7'd2, 32'd4, 32'd2, 32'd3, 32'd1, 1, 32'd5);
        drive("sub",    1, U_OP,    10'h100, 7'd3, 32'd0, 32'd2, 32'd3, 32'd0, 1, 32'hFFFFFFFF);
        drive("addi",   1, U_IMM,   10'h100, 7'd4, 32'd0, 32'd2, 32'd3, 32'd1, 1, 32'd3);
        drive("slt",    1, U_OP,    10'h002, 7'd5, 32'd0, 32'h80000000, 32'd1, 32'd0, 1, 32'd1);
        drive("sltu",   1, U_OP,    10'h003, 7'd6, 32'd0, 32'h80000000, 32'd1, 32'd0, 1, 32'd0);
        drive("srl",    1, U_OP,    10'h005, 7'd7, 32'd0, 32'h80000000, 32'd1, 32'd0, 1, 32'h40000000);
        drive("sra",    1, U_OP,    10'h105, 7'd8, 32'd0, 32'h80000000, 32'd1, 32'd0, 1, 32'hC0000000);
        drive("sll",    1, U_OP,    10'h001, 7'd9, 32'd0, 32'h80000000, 32'd1, 32'd0, 1, 32'd0);
        drive("srai",   1, U_IMM,   10'h105, 7'd10, 32'd0, 32'hF0000010, 32'd0, 32'h404, 1, 32'hFF000001);
        drive("sll31",  1, U_OP,    10'h001, 7'd11, 32'd0, 32'd1, 32'h3F, 32'd0, 1, 32'h80000000);
        drive("xori",   1, U_IMM,   10'h004, 7'd12, 32'd0, 32'h0F0F0F0F, 32'd0, 32'hFFFFFFFF, 1, 32'hF0F0F0F0);
        drive("other",  1, 7'b1100011, 10'h000, 7'd13, 32'd8, 32'd7, 32'd9, 32'd3, 1, 32'd0);
        drive("idle",   0, U_OP,    10'h000, 7'd14, 32'd0, 32'd6, 32'd1, 32'd0, 1, 32'd7);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 2; k++) begin
                drive("op sweep", 1, U_OP, {1'b0, k[0], 5'b0, f[2:0]}, 7'($urandom_range(0, 127)),
                      32'd0, $urandom, $urandom, 32'd0, 0, 32'd0);
                drive("opimm sweep", 1, U_IMM, {1'b0, k[0], 5'b0, f[2:0]}, 7'($urandom_range(0, 127)),
                      32'd0, $urandom, $urandom, $urandom, 0, 32'd0);
            end
        end
        drive("auipc wrap", 1, U_AUIPC, 10'h000, 7'd1, 32'hFFFFFFF0, 32'd0, 32'd0, 32'h20, 1, 32'h10);

        // Asynchronous reset between edges while a valid writeback is held.
        drive("pre reset", 1, U_OP, 10'h006, 7'd42, 32'd0, 32'h00F0, 32'h0F00, 32'd0, 1, 32'h0FF0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async clear", {o_valid, o_addr, o_data}, '0);
        check("bypass in reset", bypass, {1'b1, 7'd42, 32'h0FF0});
        @(posedge clk);
        #1;
        check("held in reset", {o_valid, o_addr, o_data}, '0);
        #2 rst_n = 1'b1;
        drive("post reset", 1, U_OP, 10'h007, 7'd99, 32'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 1, 32'h0F000F00);
        drive("tail", 0, U_LUI, 10'h000, 7'd0, 32'd0, 32'd0, 32'd0, 32'h12345000, 1, 32'h12345000);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
